vx_tl_mem_bridge: RTL
=====================

# vx_tl_mem_bridge

Parametrised bridge between the Vortex core memory port (mem_req/mem_rsp, one cache line per beat) and a single-beat TileLink-UL master port. It replaces direct tag-to-source wiring with a bounded in-flight table that renumbers core tags to compact TL source IDs, so many requests can be outstanding. It selects PutFull, PutPartial or Get per request, absorbs write acks, and registers both channels. It sits between VX_core and the tile's TL crossbar inside the core wrapper.

## Interface
- DATA_WIDTH, 128, beat/line width in bits; power of two, ≥32
- ADDR_WIDTH, 28, core line-address width
- CORE_TAG_WIDTH, 15, core request tag width
- SOURCE_WIDTH, 3, TL source width; table depth = 2**SOURCE_WIDTH
- FWD_WRITE_ACK, 0, 1 = forward AccessAck to the core as a response with data zeroed
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- core_req_valid/core_req_ready  in/out  1  core request handshake
- core_req_rw  in  1  1 = write
- core_req_byteen  in  DATA_WIDTH/8  write byte enables
- core_req_addr  in  ADDR_WIDTH  line address
- core_req_data  in  DATA_WIDTH  write data
- core_req_tag  in  CORE_TAG_WIDTH  request tag
- core_rsp_valid/core_rsp_ready  out/in  1  response handshake
- core_rsp_data  out  DATA_WIDTH; core_rsp_tag  out  CORE_TAG_WIDTH
- tl_a_valid/tl_a_ready  out/in  1; tl_a_opcode out 3; tl_a_param out 3; tl_a_size out 4; tl_a_source out SOURCE_WIDTH; tl_a_address out ADDR_WIDTH+log2(DATA_WIDTH/8); tl_a_mask out DATA_WIDTH/8; tl_a_data out DATA_WIDTH; tl_a_corrupt out 1
- tl_d_valid/tl_d_ready  in/out  1; tl_d_opcode in 3; tl_d_source in SOURCE_WIDTH; tl_d_data in DATA_WIDTH; tl_d_denied in 1; tl_d_corrupt in 1
- inflight_count  out  SOURCE_WIDTH+1  occupied table slots
- idle  out  1  table empty and both output registers empty
- err  out  1  sticky: denied, corrupt, or unknown/unused source seen

## Operation
- Table: per slot valid, rw, core tag. Slot index is the TL source.
- Request accept: core_req_ready = free slot exists AND (A register empty OR tl_a_ready). On accept, allocate the lowest-index free slot. Load the A register with: opcode = rw ? (&byteen ? 0 PutFull : 1 PutPartial) : 4 Get; size = log2(DATA_WIDTH/8); address = {addr, zeros}; mask = rw ? byteen : all ones; data = core data (don't-care on Get, driven as-is); param = 0; corrupt = 0.
- A register holds tl_a_* stable while tl_a_valid && !tl_a_ready.
- D handling, source slot valid:
  - Opcode 1 AccessAckData: tl_d_ready = response register empty OR core_rsp_ready. On the beat, load {data, stored tag} and free the slot.
  - Opcode 0 AccessAck, FWD_WRITE_ACK=0: tl_d_ready = 1; free the slot and produce no response.
  - Opcode 0 AccessAck, FWD_WRITE_ACK=1: handled like AccessAckData with data zeroed.
- D handling, other cases:
  - Source slot invalid: tl_d_ready = 1; beat is dropped and err is set.
  - Denied or corrupt: data is still forwarded (or the ack consumed), the slot is freed and err is set.
- Simultaneous alloc and free in one cycle: both occur. A slot freed in cycle N is allocatable only from N+1. inflight_count nets +1−1 = 0.
- Full table: core_req_ready = 0 until a free occurs. A request whose free slot appears in cycle N is accepted no earlier than N+1.
- Reset, including mid-transfer: all slots, both registers, err and inflight_count go to 0, and outstanding TL transactions are forgotten. Reset values: tl_a_valid=0, core_rsp_valid=0, core_req_ready=0 during reset, tl_d_ready=0 during reset, idle=1 after reset.

## Timing
- Core accept in cycle N → tl_a_valid in N+1.
- D beat in N → core_rsp_valid in N+1.
- Sustained throughput is 1 request/cycle and 1 response/cycle with ready held high.
- No combinational path from tl_a_ready to tl_a_valid. No combinational path from core_rsp_ready to core_rsp_valid. Ready paths are combinational only via the register-empty-or-draining term.
- Slot search is a priority encoder over table valid bits in one cycle.

## Structure
- Shared package vx_tl_pkg: TL opcode localparams (Get=4, PutFull=0, PutPartial=1, AccessAck=0, AccessAckData=1) and size/log2 helper functions.
- One sub-module, vx_tl_source_table: slot valid/rw/tag storage, lowest-free allocator, free-by-index, tag lookup and count.
- Top level holds the A and D output registers and err.

## Test plan
- Single Get, addr 0x0000010 → tl_a opcode 4, address 0x00000100, size 4, mask 0xFFFF, source 0; AccessAckData source 0 data 0xDEAD… → core_rsp tag matches the request, next cycle; idle returns to 1.
- Write with byteen 0xFFFF → PutFull (0). Write with byteen 0x00F0 → PutPartial (1), mask 0x00F0. AccessAck produces no core_rsp with FWD_WRITE_ACK=0; inflight_count returns to 0.
- Issue 9 Gets with SOURCE_WIDTH=3 and D held off → sources 0..7, 9th stalled (core_req_ready=0); one ack on source 3 → 9th issued on source 3 in a later cycle.
- Out-of-order responses (sources 5,1,7) with core_rsp_ready toggling → tags are correct and no beat is lost or duplicated. Same-cycle alloc and free keeps the count stable.
- D beat on an unused source, and a beat with denied=1 → err sticks at 1; the denied data is still delivered.
- Reset asserted with 4 in flight and tl_a stalled → next cycle all valids 0, inflight_count 0, idle 1; a fresh Get uses source 0.

Source files
------------

// File: rtl/vx_tl_pkg.sv
// Shared TileLink-UL definitions for the Vortex memory bridge: channel opcodes
// and beat-size helpers.
package vx_tl_pkg;

   localparam logic [2:0] TL_A_PUT_FULL_DATA    = 3'd0;
   localparam logic [2:0] TL_A_PUT_PARTIAL_DATA = 3'd1;
   localparam logic [2:0] TL_A_GET              = 3'd4;

   localparam logic [2:0] TL_D_ACCESS_ACK       = 3'd0;
   localparam logic [2:0] TL_D_ACCESS_ACK_DATA  = 3'd1;

   // Ceiling log2, usable in constant expressions.
   function automatic int unsigned tl_log2(input int unsigned value);
      int unsigned result;
      result = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) begin
            result = unsigned'(i + 1);
         end
      end
      return result;
   endfunction

   // TL a_size for a full-line beat of data_width bits.
   function automatic logic [3:0] tl_beat_size(input int unsigned data_width);
      return 4'(tl_log2(data_width / 8));
   endfunction

endpackage

// File: rtl/vx_tl_source_table.sv
// In-flight table: one slot per TL source holding the core tag and direction,
// with a lowest-free allocator, free-by-index, lookup and occupancy count.
module vx_tl_source_table
   import vx_tl_pkg::*;
#(
   parameter int SOURCE_WIDTH = 3,
   parameter int TAG_WIDTH    = 15
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    alloc_en,
   input  logic                    alloc_rw,
   input  logic [TAG_WIDTH-1:0]    alloc_tag,
   output logic                    alloc_ok,
   output logic [SOURCE_WIDTH-1:0] alloc_idx,
   input  logic                    free_en,
   input  logic [SOURCE_WIDTH-1:0] free_idx,
   input  logic [SOURCE_WIDTH-1:0] lookup_idx,
   output logic                    lookup_valid,
   output logic                    lookup_rw,
   output logic [TAG_WIDTH-1:0]    lookup_tag,
   output logic [SOURCE_WIDTH:0]   count
);

   localparam int DEPTH = 1 << SOURCE_WIDTH;

   logic [DEPTH-1:0]     valid_q, valid_d;
   logic [DEPTH-1:0]     rw_q, rw_d;
   logic [TAG_WIDTH-1:0] tag_q [DEPTH];
   logic [TAG_WIDTH-1:0] tag_d [DEPTH];
   logic [SOURCE_WIDTH:0] count_q, count_d;

   // Allocation looks only at registered valid bits, so a slot freed this
   // cycle is not handed out again until the next one.
   always_comb begin
      alloc_ok  = 1'b0;
      alloc_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!valid_q[i]) begin
            alloc_ok  = 1'b1;
            alloc_idx = SOURCE_WIDTH'(i);
         end
      end
   end

   always_comb begin
      lookup_valid = valid_q[lookup_idx];
      lookup_rw    = rw_q[lookup_idx];
      lookup_tag   = tag_q[lookup_idx];
      count        = count_q;
   end

   always_comb begin
      valid_d = valid_q;
      rw_d    = rw_q;
      tag_d   = tag_q;
      count_d = count_q;
      if (free_en) begin
         valid_d[free_idx] = 1'b0;
      end
      if (alloc_en) begin
         valid_d[alloc_idx] = 1'b1;
         rw_d[alloc_idx]    = alloc_rw;
         tag_d[alloc_idx]   = alloc_tag;
      end
      case ({alloc_en, free_en})
         2'b10:   count_d = count_q + (SOURCE_WIDTH + 1)'(1);
         2'b01:   count_d = count_q - (SOURCE_WIDTH + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q <= '0;
         rw_q    <= '0;
         tag_q   <= '{default: '0};
         count_q <= '0;
      end else begin
         valid_q <= valid_d;
         rw_q    <= rw_d;
         tag_q   <= tag_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/vx_tl_mem_bridge.sv
// Vortex core memory port to single-beat TileLink-UL master. Core tags are
// renumbered to compact TL sources through an in-flight table.
module vx_tl_mem_bridge
   import vx_tl_pkg::*;
#(
   parameter int DATA_WIDTH     = 128,
   parameter int ADDR_WIDTH     = 28,
   parameter int CORE_TAG_WIDTH = 15,
   parameter int SOURCE_WIDTH   = 3,
   parameter bit FWD_WRITE_ACK  = 1'b0
) (
   input  logic                                         clock,
   input  logic                                         reset,
   input  logic                                         core_req_valid,
   output logic                                         core_req_ready,
   input  logic                                         core_req_rw,
   input  logic [DATA_WIDTH/8-1:0]                      core_req_byteen,
   input  logic [ADDR_WIDTH-1:0]                        core_req_addr,
   input  logic [DATA_WIDTH-1:0]                        core_req_data,
   input  logic [CORE_TAG_WIDTH-1:0]                    core_req_tag,
   output logic                                         core_rsp_valid,
   input  logic                                         core_rsp_ready,
   output logic [DATA_WIDTH-1:0]                        core_rsp_data,
   output logic [CORE_TAG_WIDTH-1:0]                    core_rsp_tag,
   output logic                                         tl_a_valid,
   input  logic                                         tl_a_ready,
   output logic [2:0]                                   tl_a_opcode,
   output logic [2:0]                                   tl_a_param,
   output logic [3:0]                                   tl_a_size,
   output logic [SOURCE_WIDTH-1:0]                      tl_a_source,
   output logic [ADDR_WIDTH+$clog2(DATA_WIDTH/8)-1:0]   tl_a_address,
   output logic [DATA_WIDTH/8-1:0]                      tl_a_mask,
   output logic [DATA_WIDTH-1:0]                        tl_a_data,
   output logic                                         tl_a_corrupt,
   input  logic                                         tl_d_valid,
   output logic                                         tl_d_ready,
   input  logic [2:0]                                   tl_d_opcode,
   input  logic [SOURCE_WIDTH-1:0]                      tl_d_source,
   input  logic [DATA_WIDTH-1:0]                        tl_d_data,
   input  logic                                         tl_d_denied,
   input  logic                                         tl_d_corrupt,
   output logic [SOURCE_WIDTH:0]                        inflight_count,
   output logic                                         idle,
   output logic                                         err
);

   localparam int BYTES     = DATA_WIDTH / 8;
   localparam int OFF_W     = tl_log2(BYTES);
   localparam int TL_ADDR_W = ADDR_WIDTH + OFF_W;

   // Handshakes: a beat transfers on a rising edge where valid && ready.
   // Valid never depends on the same channel's ready; once raised it stays up
   // with payload stable until the transfer. Ready may depend combinationally
   // on the local output register being empty or draining this cycle.

   logic                      a_valid_q, a_valid_d;
   logic [2:0]                a_opcode_q, a_opcode_d;
   logic [SOURCE_WIDTH-1:0]   a_source_q, a_source_d;
   logic [TL_ADDR_W-1:0]      a_address_q, a_address_d;
   logic [BYTES-1:0]          a_mask_q, a_mask_d;
   logic [DATA_WIDTH-1:0]     a_data_q, a_data_d;

   logic                      rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0]     rsp_data_q, rsp_data_d;
   logic [CORE_TAG_WIDTH-1:0] rsp_tag_q, rsp_tag_d;
   logic                      err_q, err_d;

   logic                      alloc_ok;
   logic [SOURCE_WIDTH-1:0]   alloc_idx;
   logic                      slot_valid;
   logic                      slot_rw;
   logic [CORE_TAG_WIDTH-1:0] slot_tag;
   logic [SOURCE_WIDTH:0]     table_count;

   logic req_fire;
   logic d_fire;
   logic d_is_data;
   logic d_is_ack;
   logic d_needs_rsp;
   logic d_bad;
   logic rsp_slot_free;
   logic free_en;

   vx_tl_source_table #(
      .SOURCE_WIDTH (SOURCE_WIDTH),
      .TAG_WIDTH    (CORE_TAG_WIDTH)
   ) u_source_table (
      .clock        (clock),
      .reset        (reset),
      .alloc_en     (req_fire),
      .alloc_rw     (core_req_rw),
      .alloc_tag    (core_req_tag),
      .alloc_ok     (alloc_ok),
      .alloc_idx    (alloc_idx),
      .free_en      (free_en),
      .free_idx     (tl_d_source),
      .lookup_idx   (tl_d_source),
      .lookup_valid (slot_valid),
      .lookup_rw    (slot_rw),
      .lookup_tag   (slot_tag),
      .count        (table_count)
   );

   always_comb begin
      core_req_ready = !reset && alloc_ok && (!a_valid_q || tl_a_ready);
      req_fire       = core_req_valid && core_req_ready;
   end

   always_comb begin
      a_valid_d   = a_valid_q;
      a_opcode_d  = a_opcode_q;
      a_source_d  = a_source_q;
      a_address_d = a_address_q;
      a_mask_d    = a_mask_q;
      a_data_d    = a_data_q;
      if (tl_a_ready) begin
         a_valid_d = 1'b0;
      end
      if (req_fire) begin
         a_valid_d   = 1'b1;
         a_source_d  = alloc_idx;
         a_address_d = {core_req_addr, {OFF_W{1'b0}}};
         a_data_d    = core_req_data;
         if (!core_req_rw) begin
            a_opcode_d = TL_A_GET;
            a_mask_d   = '1;
         end else begin
            a_opcode_d = (&core_req_byteen) ? TL_A_PUT_FULL_DATA : TL_A_PUT_PARTIAL_DATA;
            a_mask_d   = core_req_byteen;
         end
      end
   end

   // D beats that need no core response (plain acks, stray sources) are
   // always accepted so a full response register never blocks slot release.
   always_comb begin
      d_is_data     = (tl_d_opcode == TL_D_ACCESS_ACK_DATA);
      d_is_ack      = (tl_d_opcode == TL_D_ACCESS_ACK);
      d_needs_rsp   = slot_valid && (d_is_data || (d_is_ack && FWD_WRITE_ACK));
      rsp_slot_free = !rsp_valid_q || core_rsp_ready;
      tl_d_ready    = !reset && (!d_needs_rsp || rsp_slot_free);
      d_fire        = tl_d_valid && tl_d_ready;
      free_en       = d_fire && slot_valid;
      d_bad         = !slot_valid || tl_d_denied || tl_d_corrupt ||
                      !((d_is_data && !slot_rw) || (d_is_ack && slot_rw));
   end

   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_tag_d   = rsp_tag_q;
      err_d       = err_q;
      if (core_rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
      if (d_fire && d_needs_rsp) begin
         rsp_valid_d = 1'b1;
         rsp_data_d  = d_is_data ? tl_d_data : '0;
         rsp_tag_d   = slot_tag;
      end
      if (d_fire && d_bad) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         a_valid_q   <= 1'b0;
         a_opcode_q  <= '0;
         a_source_q  <= '0;
         a_address_q <= '0;
         a_mask_q    <= '0;
         a_data_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_tag_q   <= '0;
         err_q       <= 1'b0;
      end else begin
         a_valid_q   <= a_valid_d;
         a_opcode_q  <= a_opcode_d;
         a_source_q  <= a_source_d;
         a_address_q <= a_address_d;
         a_mask_q    <= a_mask_d;
         a_data_q    <= a_data_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_tag_q   <= rsp_tag_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      tl_a_valid     = a_valid_q;
      tl_a_opcode    = a_opcode_q;
      tl_a_param     = 3'd0;
      tl_a_size      = tl_beat_size(DATA_WIDTH);
      tl_a_source    = a_source_q;
      tl_a_address   = a_address_q;
      tl_a_mask      = a_mask_q;
      tl_a_data      = a_data_q;
      tl_a_corrupt   = 1'b0;
      core_rsp_valid = rsp_valid_q;
      core_rsp_data  = rsp_data_q;
      core_rsp_tag   = rsp_tag_q;
      inflight_count = table_count;
      idle           = (table_count == '0) && !a_valid_q && !rsp_valid_q;
      err            = err_q;
   end

endmodule
